// File: rtl/rect_plotter_if.sv
// Request/pixel bus between a sprite datapath (master) and the rectangle plotter (slave).
interface rect_plotter_if #(
    parameter int unsigned CW = 3
) ();
    logic          start;
    logic [7:0]    start_x;
    logic [7:0]    start_y;
    logic [7:0]    width;
    logic [7:0]    height;
    logic [CW-1:0] colour;
    logic          hole_en;
    logic [7:0]    hole_y;
    logic [7:0]    hole_h;
    logic [CW-1:0] hole_colour;
    logic          busy;
    logic          done;
    logic [7:0]    x_out;
    logic [6:0]    y_out;
    logic [CW-1:0] colour_out;
    logic          plot;

    modport master (
        output start, start_x, start_y, width, height, colour,
               hole_en, hole_y, hole_h, hole_colour,
        input  busy, done, x_out, y_out, colour_out, plot
    );

    modport slave (
        input  start, start_x, start_y, width, height, colour,
               hole_en, hole_y, hole_h, hole_colour,
        output busy, done, x_out, y_out, colour_out, plot
    );
endinterface

// File: rtl/rect_plotter.sv
// Rectangle rasterizer: one pixel per clock, optional hole band recolour, off-screen clipping.
module rect_plotter #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned CW       = 3
) (
    input  logic          clk,
    input  logic          resetn,
    rect_plotter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // latched request
    logic [7:0]    sx_q, sy_q, w_q, h_q, hy_q, hh_q;
    logic [CW-1:0] col_q, hcol_q;
    logic          hen_q;

    // coordinates of the pixel currently on the outputs
    logic [7:0] cx_q, cy_q, cx_d, cy_d;

    logic accept;
    logic last_col, last_px;

    // next values of the registered outputs
    logic          busy_d, done_d, plot_d;
    logic [7:0]    x_d;
    logic [6:0]    y_d;
    logic [CW-1:0] colour_d;

    // pixel source: live bus inputs for the first pixel, latched copy afterwards
    logic [7:0]    bx, by, bhy, bhh;
    logic [CW-1:0] bcol, bhcol;
    logic          bhen;
    logic [8:0]    px, py, hole_end;
    logic          on_screen, in_hole;

    assign accept   = (state_q == S_IDLE) && bus.start;
    assign last_col = (cx_q == 8'(w_q - 8'd1));
    assign last_px  = last_col && (cy_q == 8'(h_q - 8'd1));

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // next state and raster counter advance
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cx_d = 8'd0;
                    cy_d = 8'd0;
                    if (bus.width == 8'd0 || bus.height == 8'd0) state_d = S_DONE;
                    else                                          state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (last_px) begin
                    state_d = S_DONE;
                end else if (last_col) begin
                    cx_d = 8'd0;
                    cy_d = 8'(cy_q + 8'd1);
                end else begin
                    cx_d = 8'(cx_q + 8'd1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // pixel address, clipping and hole colour for the pixel emitted at the next edge
    always_comb begin
        bx    = sx_q;
        by    = sy_q;
        bcol  = col_q;
        bhen  = hen_q;
        bhy   = hy_q;
        bhh   = hh_q;
        bhcol = hcol_q;
        if (state_q == S_IDLE) begin
            bx    = bus.start_x;
            by    = bus.start_y;
            bcol  = bus.colour;
            bhen  = bus.hole_en;
            bhy   = bus.hole_y;
            bhh   = bus.hole_h;
            bhcol = bus.hole_colour;
        end
        px        = 9'(bx) + 9'(cx_d);
        py        = 9'(by) + 9'(cy_d);
        hole_end  = 9'(bhy) + 9'(bhh);
        on_screen = (px < 9'(SCREEN_W)) && (py < 9'(SCREEN_H));
        in_hole   = bhen && (py >= 9'(bhy)) && (py < hole_end);
    end

    // output next-values derived from the next state
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        plot_d   = (state_d == S_DRAW) && on_screen;
        x_d      = px[7:0];
        y_d      = py[6:0];
        colour_d = in_hole ? bhcol : bcol;
    end

    // request latch, counters and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sx_q           <= 8'd0;
            sy_q           <= 8'd0;
            w_q            <= 8'd0;
            h_q            <= 8'd0;
            hy_q           <= 8'd0;
            hh_q           <= 8'd0;
            col_q          <= '0;
            hcol_q         <= '0;
            hen_q          <= 1'b0;
            cx_q           <= 8'd0;
            cy_q           <= 8'd0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.plot       <= 1'b0;
            bus.x_out      <= 8'd0;
            bus.y_out      <= 7'd0;
            bus.colour_out <= '0;
        end else begin
            if (accept) begin
                sx_q   <= bus.start_x;
                sy_q   <= bus.start_y;
                w_q    <= bus.width;
                h_q    <= bus.height;
                hy_q   <= bus.hole_y;
                hh_q   <= bus.hole_h;
                col_q  <= bus.colour;
                hcol_q <= bus.hole_colour;
                hen_q  <= bus.hole_en;
            end
            cx_q           <= cx_d;
            cy_q           <= cy_d;
            bus.busy       <= busy_d;
            bus.done       <= done_d;
            bus.plot       <= plot_d;
            bus.x_out      <= x_d;
            bus.y_out      <= y_d;
            bus.colour_out <= colour_d;
        end
    end

endmodule
